// File: rtl/mptw_mem_arbiter_if.sv
// Memory port bundle shared by the walker stages and the system memory side.
// NUM_PORTS > 1 carries one lane per requester; NUM_PORTS = 1 is the shared port.
interface mptw_mem_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 1,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64
);
    logic [NUM_PORTS-1:0]                     req;
    logic [NUM_PORTS-1:0]                     gnt;
    logic [NUM_PORTS-1:0]                     valid;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata;
    logic [NUM_PORTS-1:0]                     we;
    logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   be;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rdata;
    logic [NUM_PORTS-1:0]                     error;

    modport master (
        output req, addr, wdata, we, be,
        input  gnt, valid, rdata, error
    );

    modport slave (
        input  req, addr, wdata, we, be,
        output gnt, valid, rdata, error
    );
endinterface

// File: rtl/mptw_mem_arbiter.sv
// Shares one memory port among the MPT walker stages with in-order response routing.
// Define MPTW_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mptw_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    mptw_mem_arbiter_if.slave                 req_mem,
    mptw_mem_arbiter_if.master                mem,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              spurious_rsp_o
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef logic [ID_W-1:0]  req_id_t;
    typedef logic [PTR_W-1:0] ptr_t;

    req_id_t            id_fifo [MAX_OUTSTANDING];
    ptr_t               wr_ptr;
    ptr_t               rd_ptr;
    logic [CNT_W-1:0]   count;
    req_id_t            sel;
    req_id_t            hold_sel;
    req_id_t            head;
    logic               hold_valid;
    logic               any_req;
    logic               full;
    logic               fifo_empty;
    logic               mem_req_c;
    logic               xfer;
    logic               rsp_fire;
`ifndef MPTW_ARB_FIXED_PRIO_EN
    req_id_t            rr_ptr;
`endif

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign any_req    = |req_mem.req;
    assign full       = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign mem_req_c  = any_req && !full;
    assign xfer       = mem_req_c && mem.gnt[0];
    assign rsp_fire   = mem.valid[0] && !fifo_empty;
    assign head       = id_fifo[rd_ptr];

    // A requester that was offered but not accepted keeps the selection until it transfers.
    always_comb begin : select_requester
        // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
        sel = '0;
`ifdef MPTW_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_mem.req[req_id_t'(i)]) sel = req_id_t'(i);
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            if (req_mem.req[req_id_t'(idx)]) sel = req_id_t'(idx);
        end
`endif
        if (hold_valid && req_mem.req[hold_sel]) sel = hold_sel;
    end

    assign mem.req[0]   = mem_req_c;
    assign mem.addr[0]  = mem_req_c ? req_mem.addr[sel]  : '0;
    assign mem.wdata[0] = mem_req_c ? req_mem.wdata[sel] : '0;
    assign mem.we[0]    = mem_req_c ? req_mem.we[sel]    : 1'b0;
    assign mem.be[0]    = mem_req_c ? req_mem.be[sel]    : '0;

    always_comb begin : route
        req_mem.gnt   = '0;
        req_mem.valid = '0;
        req_mem.rdata = '0;
        req_mem.error = '0;
        if (xfer) req_mem.gnt[sel] = 1'b1;
        if (rsp_fire) begin
            req_mem.valid[head] = 1'b1;
            req_mem.rdata[head] = mem.rdata[0];
            req_mem.error[head] = mem.error[0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            hold_valid     <= 1'b0;
            hold_sel       <= '0;
            spurious_rsp_o <= 1'b0;
`ifndef MPTW_ARB_FIXED_PRIO_EN
            rr_ptr         <= '0;
`endif
        end else begin
            if (xfer) begin
                wr_ptr <= ptr_inc(wr_ptr);
`ifndef MPTW_ARB_FIXED_PRIO_EN
                rr_ptr <= (sel == req_id_t'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
`endif
            end
            if (rsp_fire) rd_ptr <= ptr_inc(rd_ptr);
            if (xfer && !rsp_fire) begin
                count <= count + 1'b1;
            end else if (!xfer && rsp_fire) begin
                count <= count - 1'b1;
            end
            if (mem.valid[0] && fifo_empty) spurious_rsp_o <= 1'b1;
            hold_valid <= any_req && !xfer;
            hold_sel   <= sel;
        end
    end

    // NOTE: the ID storage has no reset; entries are only read once the count says they were written.
    always_ff @(posedge clk_i) begin
        if (xfer) id_fifo[wr_ptr] <= sel;
    end

    assign outstanding_o = count;
endmodule

// File: tb/tb_mptw_mem_arbiter.sv
// Self-checking bench for mptw_mem_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_mptw_mem_arbiter;
    localparam int NUM_REQ = 3;
    localparam int DW      = 64;
    localparam int AW      = 64;
    localparam int MO      = 4;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic [2:0] outstanding_o;
    logic       spurious_rsp_o;
    int         errors = 0;
    int         checks = 0;

    // reference model state
    int              q[$];
    int              rr        = 0;
    int              presented = -1;
    bit [NUM_REQ-1:0] pending;

    mptw_mem_arbiter_if #(.NUM_PORTS(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) req_if ();
    mptw_mem_arbiter_if #(.NUM_PORTS(1),       .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

    mptw_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_mem        (req_if),
        .mem            (mem_if),
        .outstanding_o  (outstanding_o),
        .spurious_rsp_o (spurious_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        req_if.req   = '0;
        req_if.addr  = '0;
        req_if.wdata = '0;
        req_if.we    = '0;
        req_if.be    = '0;
        mem_if.gnt   = '0;
        mem_if.valid = '0;
        mem_if.rdata = '0;
        mem_if.error = '0;
    endtask

    // Next requester to be offered, from the arbitration rules rather than the RTL encoding.
    function automatic int model_sel(input bit [NUM_REQ-1:0] rq);
        if (presented >= 0 && rq[presented]) return presented;
`ifdef MPTW_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (rq[i]) return i;
`else
        for (int k = 0; k < NUM_REQ; k++) if (rq[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
`endif
        return 0;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d required 0", outstanding_o); end
        checks++;
        if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b required 0", spurious_rsp_o); end
        checks++;
        if (mem_if.req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_if.req); end
        checks++;
        if (req_if.gnt !== 3'b000 || req_if.valid !== 3'b000) begin
            errors++; $display("FAIL reset_gnt_valid: got gnt=%b valid=%b required 000/000", req_if.gnt, req_if.valid);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_addr [3] = '{64'h100, 64'h200, 64'h300};
        req_if.addr[0] = 64'h100;
        req_if.addr[1] = 64'h200;
        req_if.addr[2] = 64'h300;
        req_if.req     = 3'b111;
        mem_if.gnt     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (mem_if.addr[0] !== exp_addr[c]) begin errors++; $display("FAIL rr_addr[%0d]: got %h required %h", c, mem_if.addr[0], exp_addr[c]); end
            checks++;
            if (req_if.gnt !== (3'b001 << c)) begin errors++; $display("FAIL rr_gnt[%0d]: got %b required %b", c, req_if.gnt, 3'b001 << c); end
            checks++;
            if (outstanding_o !== 3'(c)) begin errors++; $display("FAIL rr_outstanding[%0d]: got %0d required %0d", c, outstanding_o, c); end
            @(negedge clk_i);
            req_if.req[c] = 1'b0;
        end
        mem_if.gnt = 1'b0;
        #1;
        checks++;
        if (mem_if.req !== 1'b0 || outstanding_o !== 3'd3) begin
            errors++; $display("FAIL rr_after: got mem_req=%b outstanding=%0d required 0/3", mem_if.req, outstanding_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_responses();
        @(negedge clk_i);
        for (int c = 0; c < 3; c++) begin
            mem_if.valid = 1'b1;
            mem_if.rdata = 64'(64'hA + c);
            #1;
            checks++;
            if (req_if.valid !== (3'b001 << c)) begin errors++; $display("FAIL rsp_valid[%0d]: got %b required %b", c, req_if.valid, 3'b001 << c); end
            checks++;
            if (req_if.rdata[c] !== 64'(64'hA + c)) begin errors++; $display("FAIL rsp_rdata[%0d]: got %h required %h", c, req_if.rdata[c], 64'hA + c); end
            checks++;
            if (outstanding_o !== 3'(3 - c)) begin errors++; $display("FAIL rsp_outstanding[%0d]: got %0d required %0d", c, outstanding_o, 3 - c); end
            @(negedge clk_i);
        end
        mem_if.valid = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd0 || req_if.valid !== 3'b000) begin
            errors++; $display("FAIL rsp_drained: got outstanding=%0d valid=%b required 0/000", outstanding_o, req_if.valid);
        end
        @(negedge clk_i);
    endtask

    task automatic test_full();
        req_if.req[1]  = 1'b1;
        req_if.addr[1] = 64'h400;
        mem_if.gnt     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_if.gnt !== 3'b010 || outstanding_o !== 3'(k)) begin
                errors++; $display("FAIL full_fill[%0d]: got gnt=%b outstanding=%0d required 010/%0d", k, req_if.gnt, outstanding_o, k);
            end
            @(negedge clk_i);
        end
        #1;
        checks++;
        if (mem_if.req !== 1'b0 || req_if.gnt !== 3'b000 || outstanding_o !== 3'd4) begin
            errors++; $display("FAIL full_block: got mem_req=%b gnt=%b outstanding=%0d required 0/000/4", mem_if.req, req_if.gnt, outstanding_o);
        end
        @(negedge clk_i);
        mem_if.valid = 1'b1;
        mem_if.rdata = 64'h55;
        #1;
        checks++;
        if (req_if.valid !== 3'b010 || req_if.rdata[1] !== 64'h55) begin
            errors++; $display("FAIL full_pop_rsp: got valid=%b rdata=%h required 010/55", req_if.valid, req_if.rdata[1]);
        end
        checks++;
        if (mem_if.req !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle: got mem_req=%b required 0", mem_if.req); end
        @(negedge clk_i);
        mem_if.valid = 1'b0;
        #1;
        checks++;
        if (mem_if.req !== 1'b1 || req_if.gnt !== 3'b010 || outstanding_o !== 3'd3) begin
            errors++; $display("FAIL full_next_grant: got mem_req=%b gnt=%b outstanding=%0d required 1/010/3", mem_if.req, req_if.gnt, outstanding_o);
        end
        @(negedge clk_i);
        req_if.req = '0;
        mem_if.gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_if.valid = 1'b1;
            mem_if.rdata = 64'(k);
            #1;
            checks++;
            if (req_if.valid !== 3'b010 || outstanding_o !== 3'(4 - k)) begin
                errors++; $display("FAIL full_drain[%0d]: got valid=%b outstanding=%0d required 010/%0d", k, req_if.valid, outstanding_o, 4 - k);
            end
            @(negedge clk_i);
        end
        mem_if.valid = 1'b0;
    endtask

    task automatic test_error();
        req_if.req[2]  = 1'b1;
        req_if.addr[2] = 64'h2000;
        mem_if.gnt     = 1'b1;
        #1;
        checks++;
        if (req_if.gnt !== 3'b100) begin errors++; $display("FAIL err_gnt: got %b required 100", req_if.gnt); end
        @(negedge clk_i);
        req_if.req   = '0;
        mem_if.gnt   = 1'b0;
        mem_if.valid = 1'b1;
        mem_if.error = 1'b1;
        mem_if.rdata = 64'h77;
        #1;
        checks++;
        if (req_if.valid !== 3'b100 || req_if.error !== 3'b100) begin
            errors++; $display("FAIL err_route: got valid=%b error=%b required 100/100", req_if.valid, req_if.error);
        end
        checks++;
        if (req_if.rdata[2] !== 64'h77 || req_if.rdata[0] !== 64'h0 || req_if.rdata[1] !== 64'h0) begin
            errors++; $display("FAIL err_rdata: got %h/%h/%h required 0/0/77", req_if.rdata[0], req_if.rdata[1], req_if.rdata[2]);
        end
        @(negedge clk_i);
        mem_if.valid = 1'b0;
        mem_if.error = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_spurious();
        mem_if.valid = 1'b1;
        mem_if.rdata = 64'h99;
        #1;
        checks++;
        if (req_if.valid !== 3'b000) begin errors++; $display("FAIL spur_no_valid: got %b required 000", req_if.valid); end
        @(negedge clk_i);
        mem_if.valid = 1'b0;
        #1;
        checks++;
        if (spurious_rsp_o !== 1'b1) begin errors++; $display("FAIL spur_set: got %b required 1", spurious_rsp_o); end
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if (spurious_rsp_o !== 1'b1 || outstanding_o !== 3'd0) begin
            errors++; $display("FAIL spur_sticky: got spur=%b outstanding=%0d required 1/0", spurious_rsp_o, outstanding_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL spur_reset: got %b required 0", spurious_rsp_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        // an access in flight when reset hits must come back as spurious
        req_if.req[0] = 1'b1;
        mem_if.gnt    = 1'b1;
        @(negedge clk_i);
        req_if.req = '0;
        mem_if.gnt = 1'b0;
        rst_ni     = 1'b0;
        @(negedge clk_i);
        rst_ni       = 1'b1;
        mem_if.valid = 1'b1;
        #1;
        checks++;
        if (req_if.valid !== 3'b000 || outstanding_o !== 3'd0) begin
            errors++; $display("FAIL spur_midreset: got valid=%b outstanding=%0d required 000/0", req_if.valid, outstanding_o);
        end
        @(negedge clk_i);
        mem_if.valid = 1'b0;
        #1;
        checks++;
        if (spurious_rsp_o !== 1'b1) begin errors++; $display("FAIL spur_midreset_flag: got %b required 1", spurious_rsp_o); end
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_priority();
`ifdef MPTW_ARB_FIXED_PRIO_EN
        int exp_id [4] = '{0, 0, 0, 0};
`else
        int exp_id [4] = '{0, 2, 0, 2};
`endif
        req_if.req = 3'b101;
        mem_if.gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_if.valid = (c > 0);
            #1;
            checks++;
            if (req_if.gnt !== (3'b001 << exp_id[c])) begin
                errors++; $display("FAIL prio_gnt[%0d]: got %b required %b", c, req_if.gnt, 3'b001 << exp_id[c]);
            end
            checks++;
            if (outstanding_o !== ((c > 0) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL prio_outstanding[%0d]: got %0d required %0d", c, outstanding_o, (c > 0) ? 1 : 0);
            end
            @(negedge clk_i);
        end
        req_if.req[0] = 1'b0;
        #1;
        checks++;
        if (req_if.gnt !== 3'b100) begin errors++; $display("FAIL prio_drop0: got %b required 100", req_if.gnt); end
        @(negedge clk_i);
        req_if.req = '0;
        #1;
        @(negedge clk_i);
        mem_if.valid = 1'b0;
        mem_if.gnt   = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd0) begin errors++; $display("FAIL prio_drain: got %0d required 0", outstanding_o); end
        @(negedge clk_i);
    endtask

    task automatic test_random();
        rst_ni = 1'b0;
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        q.delete();
        rr        = 0;
        presented = -1;
        pending   = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [NUM_REQ-1:0][DW-1:0] exp_rdata;
            logic [NUM_REQ-1:0]         exp_valid;
            logic [NUM_REQ-1:0]         exp_error;
            logic [NUM_REQ-1:0]         exp_gnt;
            logic [AW+DW+1+DW/8-1:0]    exp_bus;
            bit any, exp_req, fire;
            int s, h;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i]      = 1'b1;
                    req_if.addr[i]  = {$urandom, $urandom};
                    req_if.wdata[i] = {$urandom, $urandom};
                    req_if.we[i]    = 1'($urandom);
                    req_if.be[i]    = 8'($urandom);
                end
            end
            req_if.req   = pending;
            mem_if.gnt   = ($urandom_range(0, 3) != 0);
            mem_if.valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_if.rdata = {$urandom, $urandom};
            mem_if.error = ($urandom_range(0, 7) == 0);
            #1;
            any     = (pending != '0);
            exp_req = any && (q.size() < MO);
            s       = model_sel(pending);
            exp_gnt = (exp_req && mem_if.gnt[0]) ? (3'b001 << s) : 3'b000;
            exp_bus = exp_req ? {req_if.addr[s], req_if.wdata[s], req_if.we[s], req_if.be[s]} : '0;
            fire      = mem_if.valid[0] && (q.size() > 0);
            h         = fire ? q[0] : 0;
            exp_valid = fire ? (3'b001 << h) : 3'b000;
            exp_rdata = '0;
            exp_error = '0;
            if (fire) begin
                exp_rdata[h] = mem_if.rdata[0];
                exp_error[h] = mem_if.error[0];
            end
            checks++;
            if (mem_if.req[0] !== exp_req) begin errors++; $display("FAIL rand_mem_req@%0d: got %b required %b", cyc, mem_if.req, exp_req); end
            checks++;
            if ({mem_if.addr[0], mem_if.wdata[0], mem_if.we[0], mem_if.be[0]} !== exp_bus) begin
                errors++; $display("FAIL rand_bus@%0d: got addr=%h required addr=%h (sel %0d)", cyc, mem_if.addr[0], exp_bus[AW+DW+1+DW/8-1 -: AW], s);
            end
            checks++;
            if (req_if.gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt@%0d: got %b required %b", cyc, req_if.gnt, exp_gnt); end
            checks++;
            if (req_if.valid !== exp_valid) begin errors++; $display("FAIL rand_valid@%0d: got %b required %b", cyc, req_if.valid, exp_valid); end
            checks++;
            if (req_if.rdata !== exp_rdata || req_if.error !== exp_error) begin
                errors++; $display("FAIL rand_rsp@%0d: got err=%b rdata=%h required err=%b rdata=%h", cyc, req_if.error, req_if.rdata, exp_error, exp_rdata);
            end
            checks++;
            if (outstanding_o !== 3'(q.size())) begin errors++; $display("FAIL rand_outstanding@%0d: got %0d required %0d", cyc, outstanding_o, q.size()); end
            if (fire) void'(q.pop_front());
            if (exp_gnt != 3'b000) begin
                q.push_back(s);
                rr         = (s + 1) % NUM_REQ;
                pending[s] = 1'b0;
                presented  = -1;
            end else begin
                presented = any ? s : -1;
            end
            @(negedge clk_i);
        end
        idle_inputs();
        for (int n = 0; n < 2 * MO && q.size() > 0; n++) begin
            mem_if.valid = 1'b1;
            #1;
            checks++;
            if (req_if.valid !== (3'b001 << q[0])) begin errors++; $display("FAIL rand_drain: got %b required %b", req_if.valid, 3'b001 << q[0]); end
            void'(q.pop_front());
            @(negedge clk_i);
        end
        mem_if.valid = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd0 || spurious_rsp_o !== 1'b0) begin
            errors++; $display("FAIL rand_end: got outstanding=%0d spur=%b required 0/0", outstanding_o, spurious_rsp_o);
        end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_responses();
        test_full();
        test_error();
        test_spurious();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mptw_mem_arbiter.md
Name: mptw_mem_arbiter

Overview:
- Shares one memory master port between the NUM_STAGES walking-stage memory master ports of the MPT walker.
- Uses round-robin request arbitration.
- Tracks outstanding accesses in an in-order requester-ID FIFO, so that each response (valid/rdata/error) returns only to the requester that issued it.
- Sits between the walker's walking_mem_master port array and the single system-side memory port.

Parameters:
- NUM_REQ, 3, number of requesters (walking stages); must be >= 2.
- DATA_WIDTH, 64, data width of rdata/wdata.
- ADDR_WIDTH, 64, address width.
- MAX_OUTSTANDING, 4, depth of the in-flight ID FIFO; must be a power of two, >= 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_mem_req  in  [NUM_REQ]  per-requester request.
- req_mem_gnt  out  [NUM_REQ]  per-requester grant.
- req_mem_valid  out  [NUM_REQ]  per-requester response valid.
- req_mem_addr  in  [NUM_REQ][ADDR_WIDTH]  request address.
- req_mem_wdata  in  [NUM_REQ][DATA_WIDTH]  write data.
- req_mem_we  in  [NUM_REQ]  write enable.
- req_mem_be  in  [NUM_REQ][DATA_WIDTH/8]  byte enables.
- req_mem_rdata  out  [NUM_REQ][DATA_WIDTH]  read data.
- req_mem_error  out  [NUM_REQ]  response error.
- mem_req  out  1  shared port request.
- mem_gnt  in  1  shared port grant.
- mem_valid  in  1  shared port response valid.
- mem_addr  out  ADDR_WIDTH  shared port address.
- mem_wdata  out  DATA_WIDTH  shared port write data.
- mem_we  out  1  shared port write enable.
- mem_be  out  DATA_WIDTH/8  shared port byte enables.
- mem_rdata  in  DATA_WIDTH  shared port read data.
- mem_error  in  1  shared port response error.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  number of in-flight accesses.
- spurious_rsp_o  out  1  sticky flag: a response arrived with no access outstanding.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values:
  - rr_ptr = 0; FIFO empty; outstanding_o = 0; spurious_rsp_o = 0.
  - All req_mem_gnt/req_mem_valid = 0.
  - mem_req = 0.
- Arbitration (combinational):
  - sel = first i with req_mem_req[i]=1, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - full = (count == MAX_OUTSTANDING).
  - mem_req = |req_mem_req && !full.
  - mem_addr/wdata/we/be = the sel requester's fields when mem_req=1; zero otherwise.
  - req_mem_gnt[sel] = mem_req && mem_gnt; all other grants = 0.
- Handshake: an access transfers in the cycle where mem_req && mem_gnt are both 1. On transfer:
  - push sel into the FIFO;
  - rr_ptr <= (sel+1) mod NUM_REQ.
  - Zero-cycle request->grant latency; no registering on the request path.
- Request stability: once a requester raises req, it holds req and all fields until it is granted. The arbiter may switch sel only in cycles where no transfer occurs, and only when the currently selected requester's req=0.
- Responses (in order):
  - When mem_valid=1 and the FIFO is non-empty:
    - req_mem_valid[head] = 1;
    - req_mem_rdata[head] = mem_rdata; req_mem_error[head] = mem_error;
    - pop the FIFO.
  - rdata/error of non-selected requesters = 0.
  - Response latency through the block is combinational (0 cycles).
- Spurious response: mem_valid=1 with the FIFO empty is dropped, no req_mem_valid is asserted, and spurious_rsp_o is set; it clears only on reset.
- Simultaneous push and pop in the same cycle: count is unchanged; a response may be for an access granted in an earlier cycle only.
- Full FIFO: full is evaluated on the registered count, so a pop in the same cycle does not admit a new request. That request is granted one cycle later.
- Pointer arithmetic: read/write pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally; count saturates neither way.
- Reset mid-operation: FIFO cleared; in-flight responses arriving after reset are flagged as spurious.

Optional Feature:
- Macro MPTW_ARB_FIXED_PRIO_EN.
- Defined: rr_ptr is removed; sel is the lowest index with req=1, so the deepest-level walking stage wins. All other behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- NUM_REQ=3, MAX_OUTSTANDING=4; requesters 0,1,2 all hold req with addr 0x100/0x200/0x300, mem_gnt=1 every cycle -> mem_addr sequence 0x100, 0x200, 0x300; each gnt is one-hot for 1 cycle.
- Memory returns 3 responses with rdata 0xA, 0xB, 0xC, each delayed 2 cycles -> req_mem_valid[0..2] pulse in order with matching rdata; outstanding_o goes 1,2,3 then back to 0.
- Requester 1 issues continuous reads, memory never responds -> after 4 grants mem_req=0 and outstanding_o=4. One response arrives -> next grant occurs exactly 1 cycle later.
- Response with mem_error=1 for an access from requester 2 -> req_mem_error[2]=1 with req_mem_valid[2]=1; other requesters see error=0.
- mem_valid=1 with outstanding_o=0 -> no req_mem_valid asserted; spurious_rsp_o=1 and stays set until rst_ni=0.
- With MPTW_ARB_FIXED_PRIO_EN defined, requesters 0 and 2 hold req continuously -> requester 0 granted every cycle and requester 2 starved. Drop req 0 -> requester 2 granted the next cycle.
